// File: rtl/local_history_predictor.sv
// Per-PC local-history branch direction predictor with saturating counters.
// brinfo packs {valid, pc[WIDTH_ADDR-1:0], taken}, valid in the MSB.
//
// state | meaning
// CLEAR | sweep clr_idx over every counter (and history) writing init values; ready=0
// RUN   | predict from pc, train from brinfo, flush returns to CLEAR
module local_history_predictor #(
    parameter int WIDTH_PC   = 5,
    parameter int WIDTH_HIST = 10,
    parameter int WIDTH_CTR  = 2,
    parameter int IDX_MODE   = 0,
    parameter int CTR_INIT   = 0,
    parameter int WIDTH_ADDR = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WIDTH_ADDR-1:0] pc,
    output logic                  pred_taken,
    output logic                  pred_strong,
    output logic                  ready,
    input  logic                  flush,
    input  logic [WIDTH_ADDR+1:0] brinfo
);

    localparam int WIDTH_IDX    = WIDTH_PC + WIDTH_HIST;
    localparam int SIZE_PC      = 2 ** WIDTH_PC;
    localparam int SIZE_COUNTER = 2 ** WIDTH_IDX;
    localparam logic [WIDTH_CTR-1:0] CTR_MAX = {WIDTH_CTR{1'b1}};
    localparam logic [WIDTH_CTR-1:0] CTR_CLR = WIDTH_CTR'(CTR_INIT);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t                 state, state_next;
    logic [WIDTH_IDX-1:0]   clr_idx, clr_idx_next;

    logic [WIDTH_HIST-1:0]  history  [SIZE_PC];
    logic [WIDTH_CTR-1:0]   counters [SIZE_COUNTER];

    logic                   br_valid;
    logic                   br_taken;
    logic [WIDTH_ADDR-1:0]  br_pc;

    logic [WIDTH_PC-1:0]    p_sel, u_sel;
    logic [WIDTH_HIST-1:0]  p_upper, u_upper;
    logic [WIDTH_HIST-1:0]  p_hist, u_hist;
    logic [WIDTH_HIST-1:0]  p_hash, u_hash;
    logic [WIDTH_IDX-1:0]   p_idx, u_idx;
    logic [WIDTH_CTR-1:0]   p_ctr, u_ctr, u_ctr_next;
    logic                   upd_en;
    logic                   unused_bits;

    assign br_valid = brinfo[WIDTH_ADDR+1];
    assign br_pc    = brinfo[WIDTH_ADDR:1];
    assign br_taken = brinfo[0];

    // Address bits outside the select/hash fields are intentionally ignored.
    assign unused_bits = ^{pc, br_pc};

    assign p_sel   = pc[WIDTH_PC+1:2];
    assign p_upper = pc[WIDTH_PC+WIDTH_HIST+1:WIDTH_PC+2];
    assign p_hist  = history[p_sel];
    assign p_hash  = (IDX_MODE == 1) ? (p_hist ^ p_upper) : p_hist;
    assign p_idx   = {p_hash, p_sel};
    assign p_ctr   = counters[p_idx];

    assign u_sel   = br_pc[WIDTH_PC+1:2];
    assign u_upper = br_pc[WIDTH_PC+WIDTH_HIST+1:WIDTH_PC+2];
    assign u_hist  = history[u_sel];
    assign u_hash  = (IDX_MODE == 1) ? (u_hist ^ u_upper) : u_hist;
    assign u_idx   = {u_hash, u_sel};
    assign u_ctr   = counters[u_idx];

    assign ready       = (state == RUN);
    assign pred_taken  = ready & p_ctr[WIDTH_CTR-1];
    assign pred_strong = ready & ((p_ctr == CTR_MAX) | (p_ctr == '0));
    assign upd_en      = ready & br_valid & ~flush;

    always_comb begin
        u_ctr_next = u_ctr;
        if (br_taken) begin
            if (u_ctr != CTR_MAX) u_ctr_next = u_ctr + WIDTH_CTR'(1);
        end else begin
            if (u_ctr != '0) u_ctr_next = u_ctr - WIDTH_CTR'(1);
        end
    end

    always_comb begin
        state_next   = state;
        clr_idx_next = clr_idx;
        case (state)
            CLEAR: begin
                clr_idx_next = clr_idx + WIDTH_IDX'(1);
                if (&clr_idx) state_next = RUN;
            end
            RUN: begin
                if (flush) begin
                    state_next   = CLEAR;
                    clr_idx_next = '0;
                end
            end
            default: begin
                state_next   = CLEAR;
                clr_idx_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= CLEAR;
            clr_idx <= '0;
        end else begin
            state   <= state_next;
            clr_idx <= clr_idx_next;
        end
    end

    // Tables carry no reset; the CLEAR sweep initialises them.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            counters[clr_idx] <= CTR_CLR;
            if (clr_idx[WIDTH_IDX-1:WIDTH_PC] == '0)
                history[clr_idx[WIDTH_PC-1:0]] <= '0;
        end else if (upd_en) begin
            counters[u_idx] <= u_ctr_next;
            history[u_sel]  <= {u_hist[WIDTH_HIST-2:0], br_taken};
        end
    end

endmodule

// File: tb/tb_local_history_predictor.sv
// Bench for local_history_predictor: two instances (direct and XOR index) against an array model.
module tb_local_history_predictor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc = '0;
    logic        flush = 1'b0;
    logic        bv = 1'b0;
    logic        bt = 1'b0;
    logic [31:0] bpc = '0;
    logic [33:0] brinfo;
    logic [1:0]  pt, ps, rdy;

    int vectors = 0;
    int miscompares = 0;

    int hist_m [2][4];
    int ctr_m  [2][32];
    bit m_ready = 1'b0;
    int clear_left = 32;

    assign brinfo = {bv, bpc, bt};

    always #5 clk = ~clk;

    local_history_predictor #(.WIDTH_PC(2), .WIDTH_HIST(3), .WIDTH_CTR(2), .IDX_MODE(0), .CTR_INIT(0))
    u0 (.clk(clk), .rst_n(rst_n), .pc(pc), .pred_taken(pt[0]), .pred_strong(ps[0]),
        .ready(rdy[0]), .flush(flush), .brinfo(brinfo));

    local_history_predictor #(.WIDTH_PC(2), .WIDTH_HIST(3), .WIDTH_CTR(2), .IDX_MODE(1), .CTR_INIT(0))
    u1 (.clk(clk), .rst_n(rst_n), .pc(pc), .pred_taken(pt[1]), .pred_strong(ps[1]),
        .ready(rdy[1]), .flush(flush), .brinfo(brinfo));

    function automatic int m_idx(int mode, logic [31:0] a);
        int sel, h;
        sel = int'(a[3:2]);
        h   = hist_m[mode][sel];
        if (mode == 1) h = h ^ int'(a[6:4]);
        return h * 4 + sel;
    endfunction

    function automatic bit m_taken(int mode, logic [31:0] a);
        return m_ready && (ctr_m[mode][m_idx(mode, a)] >= 2);
    endfunction

    function automatic bit m_strong(int mode, logic [31:0] a);
        int c;
        c = ctr_m[mode][m_idx(mode, a)];
        return m_ready && (c == 0 || c == 3);
    endfunction

    task automatic start_clear();
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 32; i++) ctr_m[m][i] = 0;
            for (int i = 0; i < 4; i++) hist_m[m][i] = 0;
        end
        m_ready    = 1'b0;
        clear_left = 32;
    endtask

    task automatic model_edge();
        int idx, sel;
        if (!m_ready) begin
            clear_left--;
            if (clear_left == 0) m_ready = 1'b1;
        end else if (flush) begin
            start_clear();
        end else if (bv) begin
            for (int m = 0; m < 2; m++) begin
                idx = m_idx(m, bpc);
                sel = int'(bpc[3:2]);
                if (bt) ctr_m[m][idx] = (ctr_m[m][idx] == 3) ? 3 : ctr_m[m][idx] + 1;
                else    ctr_m[m][idx] = (ctr_m[m][idx] == 0) ? 0 : ctr_m[m][idx] - 1;
                hist_m[m][sel] = ((hist_m[m][sel] << 1) | int'(bt)) & 7;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        pc    = 32'h4;
        start_clear();
        #2;
        vectors++;
        if (rdy !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_ready: got %b expected 00", rdy);
        end
        vectors++;
        if (pt !== 2'b00 || ps !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_pred: got taken=%b strong=%b expected 00/00", pt, ps);
        end
    endtask

    task automatic test_clear_after_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            pc = $urandom;
            #1;
            vectors++;
            if (rdy !== 2'b00 || pt !== 2'b00) begin
                miscompares++;
                $display("FAIL clear_cycle_%0d: got ready=%b taken=%b expected 00/00", i, rdy, pt);
            end
            step();
        end
        vectors++;
        if (rdy !== 2'b11) begin
            miscompares++;
            $display("FAIL clear_done_ready: got %b expected 11", rdy);
        end
    endtask

    task automatic test_train_history();
        bv = 1'b1; bpc = 32'h4; bt = 1'b1;
        repeat (3) step();
        bv = 1'b0;
        pc = 32'h4;
        #1;
        vectors++;
        if (pt[0] !== 1'b0 || ps[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL hist111_pred: got taken=%b strong=%b expected 0/1", pt[0], ps[0]);
        end
        // XOR instance at pc 0x64 hashes to counter {001,01}, trained once to 1.
        pc = 32'h64;
        #1;
        vectors++;
        if (pt[1] !== 1'b0 || ps[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL ctr_001_01: got taken=%b strong=%b expected 0/0", pt[1], ps[1]);
        end
        pc = 32'h4;
        bv = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            vectors++;
            if (pt[0] !== (k >= 1) || ps[0] !== (k == 2)) begin
                miscompares++;
                $display("FAIL hist111_train_%0d: got taken=%b strong=%b expected %0b/%0b",
                         k, pt[0], ps[0], (k >= 1), (k == 2));
            end
        end
        bv = 1'b0;
    endtask

    task automatic test_saturation();
        bv = 1'b1; bpc = 32'h4; bt = 1'b1; pc = 32'h4;
        for (int k = 0; k < 5; k++) begin
            step();
            vectors++;
            if (pt[0] !== 1'b1 || ps[0] !== 1'b1) begin
                miscompares++;
                $display("FAIL sat_high_%0d: got taken=%b strong=%b expected 1/1", k, pt[0], ps[0]);
            end
        end
        bt = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            for (int m = 0; m < 2; m++) begin
                vectors++;
                if (pt[m] !== m_taken(m, pc) || ps[m] !== m_strong(m, pc)) begin
                    miscompares++;
                    $display("FAIL sat_low_%0d_u%0d: got taken=%b strong=%b expected %0b/%0b",
                             k, m, pt[m], ps[m], m_taken(m, pc), m_strong(m, pc));
                end
            end
        end
        vectors++;
        if (pt[0] !== 1'b0 || ps[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL sat_no_wrap: got taken=%b strong=%b expected 0/1", pt[0], ps[0]);
        end
        bv = 1'b0;
    endtask

    task automatic test_same_cycle();
        bv = 1'b1; bpc = 32'h8; bt = 1'b1;
        repeat (3) step();
        pc = 32'h8;
        #1;
        vectors++;
        if (pt[0] !== 1'b0 || ps[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL rbw_old: got taken=%b strong=%b expected 0/1", pt[0], ps[0]);
        end
        step();
        vectors++;
        if (pt[0] !== 1'b0 || ps[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL rbw_new1: got taken=%b strong=%b expected 0/0", pt[0], ps[0]);
        end
        step();
        vectors++;
        if (pt[0] !== 1'b1 || ps[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL rbw_new2: got taken=%b strong=%b expected 1/0", pt[0], ps[0]);
        end
        bv = 1'b0;
    endtask

    task automatic test_flush();
        bv = 1'b1; bpc = 32'h8; bt = 1'b1; flush = 1'b1;
        #1;
        vectors++;
        if (rdy !== 2'b11) begin
            miscompares++;
            $display("FAIL flush_cycle_ready: got %b expected 11", rdy);
        end
        step();
        flush = 1'b0; bv = 1'b0;
        for (int i = 0; i < 32; i++) begin
            pc = $urandom;
            #1;
            vectors++;
            if (rdy !== 2'b00 || pt !== 2'b00) begin
                miscompares++;
                $display("FAIL flush_clear_%0d: got ready=%b taken=%b expected 00/00", i, rdy, pt);
            end
            step();
        end
        vectors++;
        if (rdy !== 2'b11) begin
            miscompares++;
            $display("FAIL flush_done_ready: got %b expected 11", rdy);
        end
        for (int a = 0; a < 128; a += 4) begin
            pc = 32'(a);
            #1;
            vectors++;
            if (pt !== 2'b00 || ps !== 2'b11) begin
                miscompares++;
                $display("FAIL flush_init_pc%0h: got taken=%b strong=%b expected 00/11", a, pt, ps);
            end
        end
    endtask

    task automatic test_reset_mid_clear();
        rst_n = 1'b0;
        #1;
        vectors++;
        if (rdy !== 2'b00) begin
            miscompares++;
            $display("FAIL async_reset_run: got %b expected 00", rdy);
        end
        rst_n = 1'b1;
        start_clear();
        repeat (10) step();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        start_clear();
        for (int i = 0; i < 32; i++) begin
            #1;
            vectors++;
            if (rdy !== 2'b00) begin
                miscompares++;
                $display("FAIL restart_clear_%0d: got %b expected 00", i, rdy);
            end
            step();
        end
        vectors++;
        if (rdy !== 2'b11) begin
            miscompares++;
            $display("FAIL restart_done_ready: got %b expected 11", rdy);
        end
    endtask

    task automatic test_xor_mode();
        bv = 1'b1; bpc = 32'h14; bt = 1'b1;
        repeat (3) step();
        pc = 32'h14;
        #1;
        vectors++;
        if (pt[1] !== 1'b0 || ps[1] !== 1'b1) begin
            miscompares++;
            $display("FAIL xor_hist111: got taken=%b strong=%b expected 0/1", pt[1], ps[1]);
        end
        repeat (3) step();
        vectors++;
        if (pt[1] !== 1'b1 || ps[1] !== 1'b1) begin
            miscompares++;
            $display("FAIL xor_trained: got taken=%b strong=%b expected 1/1", pt[1], ps[1]);
        end
        bv = 1'b0;
        pc = 32'h4;
        #1;
        vectors++;
        if (pt !== 2'b01) begin
            miscompares++;
            $display("FAIL xor_vs_direct: got taken=%b expected 01", pt);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 500; n++) begin
            flush = ($urandom_range(63) == 0);
            bv    = 1'($urandom_range(1));
            bt    = ($urandom_range(3) != 0);
            bpc   = $urandom;
            pc    = ($urandom_range(1) == 1) ? bpc : $urandom;
            #1;
            vectors++;
            if (rdy !== {2{m_ready}}) begin
                miscompares++;
                $display("FAIL rand_ready_%0d: got %b expected %0b", n, rdy, m_ready);
            end
            for (int m = 0; m < 2; m++) begin
                vectors++;
                if (pt[m] !== m_taken(m, pc) || ps[m] !== m_strong(m, pc)) begin
                    miscompares++;
                    $display("FAIL rand_pred_%0d_u%0d: got taken=%b strong=%b expected %0b/%0b",
                             n, m, pt[m], ps[m], m_taken(m, pc), m_strong(m, pc));
                end
            end
            step();
        end
        flush = 1'b0;
        bv    = 1'b0;
    endtask

    initial begin
        test_reset();
        test_clear_after_reset();
        test_train_history();
        test_saturation();
        test_same_cycle();
        test_flush();
        test_reset_mid_clear();
        test_xor_mode();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
